axi_slave_read_channel: RTL and testbench

AXI_SLAVE_READ_CHANNEL -- requirements
Module: axi_slave_read_channel

---
 rtl/axi_slave_read_channel_if.sv | 28 ++
 rtl/axi_slave_read_channel.sv | 143 ++++++++++++++
 tb/tb_axi_slave_read_channel.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_read_channel_if.sv
// AXI read-address and read-data channel bundle between a read master and a read slave.
interface axi_slave_read_channel_if #(
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned READ_CHANNEL_WIDTH = 32,
    parameter int unsigned READ_BURST_LEN     = 8
);
    logic                          ARVALID;
    logic                          ARREADY;
    logic [ADDR_WIDTH-1:0]         ARADDR;
    logic [READ_BURST_LEN-1:0]     ARLEN;
    logic [2:0]                    ARSIZE;
    logic [1:0]                    ARBURST;
    logic                          RVALID;
    logic                          RREADY;
    logic [READ_CHANNEL_WIDTH-1:0] RDATA;
    logic                          RLAST;
    logic [1:0]                    RRESP;

    modport master (
        output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        input  ARREADY, RVALID, RDATA, RLAST, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        output ARREADY, RVALID, RDATA, RLAST, RRESP
    );
endinterface

// File: rtl/axi_slave_read_channel.sv
// AXI read slave: accepts one burst at a time, reads a 1-cycle-latency memory and
// returns beats through a 2-entry credit-managed output FIFO.
module axi_slave_read_channel #(
    parameter int unsigned ADDR_WIDTH         = 32,
    parameter int unsigned READ_CHANNEL_WIDTH = 32,
    parameter int unsigned READ_BURST_LEN     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    axi_slave_read_channel_if.slave       axi,
    output logic                          mem_ren,
    output logic [ADDR_WIDTH-1:0]         mem_raddr,
    input  logic [READ_CHANNEL_WIDTH-1:0] mem_rdata
);
    localparam int unsigned BEAT_BYTES = READ_CHANNEL_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = READ_BURST_LEN + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [READ_CHANNEL_WIDTH-1:0] data;
        logic                          last;
        logic [1:0]                    resp;
    } entry_t;

    state_t                  state_q, state_d;
    logic [READ_BURST_LEN-1:0] len_q;
    logic [1:0]              burst_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [CNT_WIDTH-1:0]    issued_q;
    logic [CNT_WIDTH-1:0]    beat_q;
    logic                    inflight_q;
    entry_t                  fifo_q [2];
    logic                    rd_ptr_q;
    logic                    wr_ptr_q;
    logic [1:0]              count_q;

    logic   arready;
    logic   issue;
    logic   pop;
    logic   push;
    logic   bad_burst;
    logic   more_to_issue;
    logic   credit_ok;
    entry_t head;
    entry_t push_entry;
    logic   unused_arsize;

    assign head          = fifo_q[rd_ptr_q];
    assign pop           = (count_q != 2'd0) && axi.RREADY;
    assign push          = inflight_q;
    assign bad_burst     = burst_q[1];
    assign more_to_issue = issued_q < (CNT_WIDTH'(len_q) + CNT_WIDTH'(1));
    // Reserve a FIFO slot for every read still in flight so a return always has room.
    assign credit_ok     = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));

    assign push_entry.data = bad_burst ? '0 : mem_rdata;
    assign push_entry.last = (beat_q == CNT_WIDTH'(len_q));
    assign push_entry.resp = bad_burst ? 2'b10 : 2'b00;

    assign axi.ARREADY = arready;
    assign axi.RVALID  = (count_q != 2'd0);
    assign axi.RDATA   = head.data;
    assign axi.RLAST   = head.last;
    assign axi.RRESP   = head.resp;
    // Unsupported bursts still pace their error beats through issue, but never touch memory.
    assign mem_ren     = issue && !bad_burst;
    assign mem_raddr   = addr_q;
    assign unused_arsize = ^axi.ARSIZE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arready = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                arready = !rst;
                if (axi.ARVALID && arready) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                issue = more_to_issue && credit_ok;
                if (pop && head.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst context, issue/beat counters and the output FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            burst_q    <= '0;
            addr_q     <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            if (axi.ARVALID && arready) begin
                len_q    <= axi.ARLEN;
                burst_q  <= axi.ARBURST;
                addr_q   <= axi.ARADDR;
                issued_q <= '0;
                beat_q   <= '0;
            end
            if (issue) begin
                issued_q <= issued_q + CNT_WIDTH'(1);
                if (burst_q == 2'b01) begin
                    addr_q <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
                end
            end
            inflight_q <= issue;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_entry;
                wr_ptr_q         <= !wr_ptr_q;
                beat_q           <= beat_q + CNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_axi_slave_read_channel.sv
// Self-checking bench for axi_slave_read_channel: directed and random bursts against a
// queue-based model of the expected beats and memory addresses.
module tb_axi_slave_read_channel;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata = '0;

    axi_slave_read_channel_if #(.ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW)) bus ();

    axi_slave_read_channel #(.ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (bus),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    resp;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         got_q[$];
    logic [AW-1:0] exp_ren_q[$];
    logic [AW-1:0] ren_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issued_n, popped_n, max_occ, stab_err;
    int first_ren_cyc, first_rv_cyc, last_pop_cyc;
    logic  prev_v = 1'b0;
    logic  prev_r = 1'b0;
    beat_t prev_b;
    logic [31:0] tag = 32'h1234_5678;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ tag;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: data for the strobed address one cycle later, noise otherwise.
    always @(posedge clk) mem_rdata <= mem_ren ? mem_word(mem_raddr) : DW'($urandom());

    always @(negedge clk) begin
        beat_t b;
        b.data = bus.RDATA;
        b.last = bus.RLAST;
        b.resp = bus.RRESP;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (mem_ren) begin
                ren_q.push_back(mem_raddr);
                issued_n++;
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
            end
            if (bus.RVALID && first_rv_cyc < 0) first_rv_cyc = cyc;
            if (bus.RVALID && bus.RREADY) begin
                got_q.push_back(b);
                popped_n++;
                last_pop_cyc = cyc;
            end
            if (issued_n - popped_n > max_occ) max_occ = issued_n - popped_n;
            if (prev_v && !prev_r && (!bus.RVALID || b !== prev_b)) stab_err++;
            prev_v = bus.RVALID;
            prev_r = bus.RREADY;
            prev_b = b;
        end
    end

    task automatic clear_mon();
        exp_q.delete(); got_q.delete(); exp_ren_q.delete(); ren_q.delete();
        issued_n = 0; popped_n = 0; max_occ = 0; stab_err = 0;
        first_ren_cyc = -1; first_rv_cyc = -1; last_pop_cyc = -1;
    endtask

    // Model: beat i of a burst reads start+4*i (INCR) or start (FIXED); others return SLVERR zeros.
    task automatic build_exp(input logic [AW-1:0] addr, input int len, input logic [1:0] burst);
        for (int i = 0; i <= len; i++) begin
            logic [AW-1:0] a;
            beat_t e;
            a = (burst == 2'b01) ? addr + AW'(i * 4) : addr;
            e.data = burst[1] ? '0 : mem_word(a);
            e.resp = burst[1] ? 2'b10 : 2'b00;
            e.last = (i == len);
            exp_q.push_back(e);
            if (!burst[1]) exp_ren_q.push_back(a);
        end
    endtask

    task automatic do_ar(input logic [AW-1:0] addr, input int len, input logic [1:0] burst, output int hs);
        bit ok = 1'b0;
        hs = -1;
        @(posedge clk); #1;
        bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.ARLEN = LW'(len);
        bus.ARBURST = burst; bus.ARSIZE = 3'd2;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ARREADY) begin hs = cyc; ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL ar_handshake_timeout got none required handshake"); end
    endtask

    // mode 0: RREADY high; mode 1: 1,0,0 repeating; mode 2: random.
    task automatic collect(input int mode);
        for (int k = 0; k < 2000 && got_q.size() < exp_q.size(); k++) begin
            bus.RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.RREADY = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0;
        bus.ARBURST = '0; bus.RREADY = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 7;
        if (bus.ARREADY !== 1'b0) begin errors++; $display("FAIL reset_arready got %b required 0", bus.ARREADY); end
        if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b required 0", bus.RVALID); end
        if (bus.RLAST !== 1'b0) begin errors++; $display("FAIL reset_rlast got %b required 0", bus.RLAST); end
        if (bus.RRESP !== 2'b00) begin errors++; $display("FAIL reset_rresp got %b required 00", bus.RRESP); end
        if (bus.RDATA !== '0) begin errors++; $display("FAIL reset_rdata got %h required 0", bus.RDATA); end
        if (mem_ren !== 1'b0) begin errors++; $display("FAIL reset_mem_ren got %b required 0", mem_ren); end
        if (mem_raddr !== '0) begin errors++; $display("FAIL reset_mem_raddr got %h required 0", mem_raddr); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL reset_release_arready got %b required 1", bus.ARREADY); end
    endtask

    task automatic test_incr();
        int hs;
        clear_mon();
        build_exp(32'h100, 3, 2'b01);
        bus.RREADY = 1'b1;
        do_ar(32'h100, 3, 2'b01, hs);
        collect(0);
        checks += 2;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL incr_beats got %0d required %0d", got_q.size(), exp_q.size()); end
        if (ren_q.size() != exp_ren_q.size()) begin errors++; $display("FAIL incr_reads got %0d required %0d", ren_q.size(), exp_ren_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL incr_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i < exp_ren_q.size() && i < ren_q.size(); i++) begin
            checks++;
            if (ren_q[i] !== exp_ren_q[i]) begin errors++; $display("FAIL incr_raddr%0d got %h required %h", i, ren_q[i], exp_ren_q[i]); end
        end
        checks += 4;
        if (first_ren_cyc != hs + 1) begin errors++; $display("FAIL incr_ren_latency got %0d required %0d", first_ren_cyc - hs, 1); end
        if (first_rv_cyc != hs + 3) begin errors++; $display("FAIL incr_rvalid_latency got %0d required %0d", first_rv_cyc - hs, 3); end
        if (last_pop_cyc != hs + 6) begin errors++; $display("FAIL incr_back_to_back last_pop got %0d required %0d", last_pop_cyc - hs, 6); end
        @(negedge clk);
        if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL incr_arready_after got %b required 1", bus.ARREADY); end
    endtask

    task automatic test_fixed();
        int hs;
        clear_mon();
        build_exp(32'h40, 2, 2'b00);
        bus.RREADY = 1'b1;
        do_ar(32'h40, 2, 2'b00, hs);
        collect(0);
        checks += 2;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fixed_beats got %0d required %0d", got_q.size(), exp_q.size()); end
        if (ren_q.size() != exp_ren_q.size()) begin errors++; $display("FAIL fixed_reads got %0d required %0d", ren_q.size(), exp_ren_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fixed_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i < exp_ren_q.size() && i < ren_q.size(); i++) begin
            checks++;
            if (ren_q[i] !== exp_ren_q[i]) begin errors++; $display("FAIL fixed_raddr%0d got %h required %h", i, ren_q[i], exp_ren_q[i]); end
        end
    endtask

    task automatic test_stall();
        int hs;
        clear_mon();
        build_exp(32'h1000, 7, 2'b01);
        bus.RREADY = 1'b0;
        do_ar(32'h1000, 7, 2'b01, hs);
        collect(1);
        checks += 3;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_beats got %0d required %0d", got_q.size(), exp_q.size()); end
        if (stab_err != 0) begin errors++; $display("FAIL stall_stability got %0d violations required 0", stab_err); end
        if (max_occ > 2) begin errors++; $display("FAIL stall_occupancy got %0d required <=2", max_occ); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_slverr();
        int hs;
        clear_mon();
        build_exp(32'h80, 1, 2'b10);
        bus.RREADY = 1'b1;
        do_ar(32'h80, 1, 2'b10, hs);
        collect(0);
        checks += 2;
        if (ren_q.size() != 0) begin errors++; $display("FAIL slverr_mem_ren got %0d reads required 0", ren_q.size()); end
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL slverr_beats got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL slverr_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_wrap();
        int hs;
        clear_mon();
        build_exp(32'hFFFF_FFFC, 1, 2'b01);
        bus.RREADY = 1'b1;
        do_ar(32'hFFFF_FFFC, 1, 2'b01, hs);
        collect(0);
        checks += 2;
        if (ren_q.size() != exp_ren_q.size()) begin errors++; $display("FAIL wrap_reads got %0d required %0d", ren_q.size(), exp_ren_q.size()); end
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_beats got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_ren_q.size() && i < ren_q.size(); i++) begin
            checks++;
            if (ren_q[i] !== exp_ren_q[i]) begin errors++; $display("FAIL wrap_raddr%0d got %h required %h", i, ren_q[i], exp_ren_q[i]); end
        end
    endtask

    task automatic test_held_ar();
        int hs_a;
        int hs_b = -1;
        int pop_a;
        clear_mon();
        build_exp(32'h2000, 3, 2'b01);
        build_exp(32'h3000, 1, 2'b00);
        bus.RREADY = 1'b1;
        do_ar(32'h2000, 3, 2'b01, hs_a);
        bus.ARVALID = 1'b1; bus.ARADDR = 32'h3000; bus.ARLEN = LW'(1); bus.ARBURST = 2'b00;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ARREADY) begin hs_b = cyc; break; end
        end
        pop_a = last_pop_cyc;
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        collect(0);
        checks += 2;
        if (hs_b != pop_a + 1) begin errors++; $display("FAIL held_ar_accept got cycle %0d required %0d", hs_b, pop_a + 1); end
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL held_ar_beats got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL held_ar_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int hs;
        clear_mon();
        build_exp(32'h500, 7, 2'b01);
        bus.RREADY = 1'b1;
        do_ar(32'h500, 7, 2'b01, hs);
        for (int k = 0; k < 100 && got_q.size() < 2; k++) begin @(posedge clk); #1; end
        rst = 1'b1; bus.RREADY = 1'b0;
        @(posedge clk); #1;
        checks += 3;
        if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %b required 0", bus.RVALID); end
        if (bus.ARREADY !== 1'b0) begin errors++; $display("FAIL midrst_arready_in_reset got %b required 0", bus.ARREADY); end
        if (mem_ren !== 1'b0) begin errors++; $display("FAIL midrst_mem_ren got %b required 0", mem_ren); end
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL midrst_arready_release got %b required 1", bus.ARREADY); end
        if (bus.RVALID !== 1'b0) begin errors++; $display("FAIL midrst_rvalid_release got %b required 0", bus.RVALID); end
        bus.RREADY = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL midrst_stale_beats got %0d required 2", got_q.size()); end
        clear_mon();
        build_exp(32'h600, 0, 2'b01);
        do_ar(32'h600, 0, 2'b01, hs);
        collect(0);
        checks += 2;
        if (got_q.size() != 1) begin errors++; $display("FAIL midrst_new_beats got %0d required 1", got_q.size()); end
        if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midrst_new_beat got %h required %h", got_q[0], exp_q[0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int hs;
            logic [AW-1:0] addr;
            int len;
            logic [1:0] burst;
            addr  = $urandom() & 32'hFFFF_FFFC;
            len   = $urandom_range(0, 12);
            burst = 2'($urandom_range(0, 3));
            tag   = $urandom();
            clear_mon();
            build_exp(addr, len, burst);
            bus.RREADY = 1'b0;
            do_ar(addr, len, burst, hs);
            collect(2);
            checks += 4;
            if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_beats got %0d required %0d", n, got_q.size(), exp_q.size()); end
            if (ren_q != exp_ren_q) begin errors++; $display("FAIL rand%0d_reads got %0d reads required %0d", n, ren_q.size(), exp_ren_q.size()); end
            if (stab_err != 0) begin errors++; $display("FAIL rand%0d_stability got %0d required 0", n, stab_err); end
            if (max_occ > 2) begin errors++; $display("FAIL rand%0d_occupancy got %0d required <=2", n, max_occ); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d got %h required %h", n, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_incr();
        test_fixed();
        test_stall();
        test_slverr();
        test_wrap();
        test_held_ar();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
